// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares the single-port main RAM between the SD loader
//                (write), the CPU data port (read/write) and the CPU
//                instruction port (read). Fixed priority Ldr > Dat > Instr.
//                Data accesses outside the RAM window ([31:29] != 0) finish
//                locally. A watchdog aborts RAM accesses that never finish.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          Clock_i,
   input  logic          Reset_i,
   // SD loader
   input  logic          LdrReq_i,
   input  logic [AW-1:0] LdrAdresse_i,
   input  logic [DW-1:0] LdrDaten_i,
   output logic          LdrFertig_o,
   // CPU instruction port
   input  logic          InstrReq_i,
   input  logic [AW-1:0] InstrAdresse_i,
   output logic [DW-1:0] InstrDaten_o,
   output logic          InstrGeladen_o,
   // CPU data port
   input  logic          DatLesen_i,
   input  logic          DatSchreiben_i,
   input  logic [AW-1:0] DatAdresse_i,
   input  logic [DW-1:0] DatRein_i,
   output logic [DW-1:0] DatRaus_o,
   output logic          DatGeladen_o,
   output logic          DatGespeichert_o,
   // RAM side
   output logic          RamLesenAn_o,
   output logic          RamSchreibenAn_o,
   output logic [AW-1:0] RamAdresse_o,
   output logic [DW-1:0] RamDatenRein_o,
   input  logic [DW-1:0] RamDatenRaus_i,
   input  logic          RamDatenBereit_i,
   input  logic          RamDatenGeschrieben_i,
   // Status
   output logic          Busy_o,
   output logic          Fehler_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   typedef enum logic [1:0] {G_NONE, G_LDR, G_DAT, G_INSTR} grant_t;

   // Watchdog value at which the current ACCESS cycle is the last allowed one
   localparam logic [7:0] c_WD_LIMIT = 8'(TIMEOUT - 1);

   state_t        state_q;
   grant_t        grant_q;
   logic          op_wr_q;
   logic [7:0]    wd_q;
   logic          ldr_fertig_q;
   logic          instr_geladen_q;
   logic          dat_geladen_q;
   logic          dat_gespeichert_q;
   logic          ram_lesen_q;
   logic          ram_schreiben_q;
   logic [AW-1:0] ram_adresse_q;
   logic [DW-1:0] ram_daten_q;
   logic [DW-1:0] instr_daten_q;
   logic [DW-1:0] dat_raus_q;
   logic          fehler_q;

   logic          w_dat_periph;
   logic          w_ram_ack;
   logic          w_wd_expired;
   logic [DW-1:0] w_rdata;

   // Top three address bits select peripherals/framebuffer instead of RAM
   assign w_dat_periph = (DatAdresse_i[AW-1 -: 3] != 3'b000);
   // Only the completion matching the pending operation counts
   assign w_ram_ack    = op_wr_q ? RamDatenGeschrieben_i : RamDatenBereit_i;
   assign w_wd_expired = (wd_q == c_WD_LIMIT);
   // An aborted read hands back zero rather than whatever the bus shows
   assign w_rdata      = w_ram_ack ? RamDatenRaus_i : '0;

   // Arbitration FSM with all outputs registered
   always_ff @(posedge Clock_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q           <= S_IDLE;
         grant_q           <= G_NONE;
         op_wr_q           <= 1'b0;
         wd_q              <= '0;
         ldr_fertig_q      <= 1'b0;
         instr_geladen_q   <= 1'b0;
         dat_geladen_q     <= 1'b0;
         dat_gespeichert_q <= 1'b0;
         ram_lesen_q       <= 1'b0;
         ram_schreiben_q   <= 1'b0;
         ram_adresse_q     <= '0;
         ram_daten_q       <= '0;
         instr_daten_q     <= '0;
         dat_raus_q        <= '0;
         fehler_q          <= 1'b0;
      end else begin
         // Done pulses last exactly one cycle
         ldr_fertig_q      <= 1'b0;
         instr_geladen_q   <= 1'b0;
         dat_geladen_q     <= 1'b0;
         dat_gespeichert_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (LdrReq_i) begin
                  grant_q         <= G_LDR;
                  op_wr_q         <= 1'b1;
                  ram_adresse_q   <= LdrAdresse_i;
                  ram_daten_q     <= LdrDaten_i;
                  ram_schreiben_q <= 1'b1;
                  state_q         <= S_ACCESS;
               end else if (DatLesen_i || DatSchreiben_i) begin
                  grant_q       <= G_DAT;
                  op_wr_q       <= DatSchreiben_i;
                  ram_adresse_q <= DatAdresse_i;
                  if (DatSchreiben_i) begin
                     ram_daten_q <= DatRein_i;
                  end
                  if (w_dat_periph) begin
                     // Completed locally: pulse in the following cycle
                     state_q <= S_DONE;
                     if (DatSchreiben_i) begin
                        dat_gespeichert_q <= 1'b1;
                     end else begin
                        dat_geladen_q <= 1'b1;
                        dat_raus_q    <= '0;
                     end
                  end else begin
                     ram_schreiben_q <= DatSchreiben_i;
                     ram_lesen_q     <= ~DatSchreiben_i;
                     state_q         <= S_ACCESS;
                  end
               end else if (InstrReq_i) begin
                  grant_q       <= G_INSTR;
                  op_wr_q       <= 1'b0;
                  ram_adresse_q <= InstrAdresse_i;
                  ram_lesen_q   <= 1'b1;
                  state_q       <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               wd_q <= wd_q + 8'd1;
               if (w_ram_ack || w_wd_expired) begin
                  ram_lesen_q     <= 1'b0;
                  ram_schreiben_q <= 1'b0;
                  state_q         <= S_DONE;
                  if (!w_ram_ack) begin
                     fehler_q <= 1'b1;
                  end
                  case (grant_q)
                     G_LDR: ldr_fertig_q <= 1'b1;
                     G_DAT: begin
                        if (op_wr_q) begin
                           dat_gespeichert_q <= 1'b1;
                        end else begin
                           dat_geladen_q <= 1'b1;
                           dat_raus_q    <= w_rdata;
                        end
                     end
                     G_INSTR: begin
                        instr_geladen_q <= 1'b1;
                        instr_daten_q   <= w_rdata;
                     end
                     default: ;
                  endcase
               end
            end
            S_DONE: begin
               grant_q <= G_NONE;
               wd_q    <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign LdrFertig_o      = ldr_fertig_q;
   assign InstrGeladen_o   = instr_geladen_q;
   assign InstrDaten_o     = instr_daten_q;
   assign DatGeladen_o     = dat_geladen_q;
   assign DatGespeichert_o = dat_gespeichert_q;
   assign DatRaus_o        = dat_raus_q;
   assign RamLesenAn_o     = ram_lesen_q;
   assign RamSchreibenAn_o = ram_schreiben_q;
   assign RamAdresse_o     = ram_adresse_q;
   assign RamDatenRein_o   = ram_daten_q;
   assign Busy_o           = (state_q != S_IDLE);
   assign Fehler_o         = fehler_q;

endmodule
`default_nettype wire
